int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//  Interrupt controller downstream of timer and other peripherals. Edge-captures
//  level interrupt lines (e.g. timer int_sig_o) into pending bits and masks them.
//  Arbitrates by fixed priority (lowest index wins) and presents one request + ID
//  to the core with a req/ack/done handshake. Memory-mapped regs use the same
//  data_i/addr_i/we_i/data_o style as the other perips.
// PARAMETERS
//  NUM_SRC   8   number of interrupt sources, 1..32; source 0 = highest priority
// PORTS
//  clk         in   1        single clock, all state on posedge
//  rst         in   1        asynchronous, active-low reset (rst==0 resets)
//  int_src_i   in   NUM_SRC  level interrupt lines from peripherals
//  data_i      in   32       register write data
//  addr_i      in   32       register address, only addr_i[3:0] decoded
//  we_i        in   1        register write enable (1 = write this cycle)
//  data_o      out  32       register read data, combinational from addr_i
//  int_req_o   out  1        interrupt request to core
//  int_id_o    out  5        ID of requested/in-service source, zero-extended
//  int_ack_i   in   1        core accepts request (sampled only in REQ)
//  int_done_i  in   1        core finished handler, mret (sampled only in SERVICE)
// BEHAVIOUR
//  Reset: all regs 0, state IDLE, int_req_o=0, int_id_o=0, src_q=0.
//  Regs (addr_i[3:0]); unmapped reads 0, writes ignored:
//   0x0 CTRL    bit0 global enable (RW); bits[3:2] state (RO: 0 IDLE,1 REQ,2 SERVICE)
//   0x4 ENABLE  per-source mask, RW, bits >= NUM_SRC read 0
//   0x8 PENDING read pending; write-1-to-clear
//   0xC CLAIM   read {26'b0, state[1:0]... } = {24'b0, state, 1'b0, id[4:0]} with
//               state in bits[7:6]; any write in SERVICE = complete (as int_done_i)
//  Capture: src_q <= int_src_i each cycle; pending[i] set when int_src_i[i] & ~src_q[i].
//   Edge at cycle T -> pending visible T+1. Line high at reset release = edge.
//   Same-cycle set edge and W1C/ack clear on same bit: set wins.
//  eligible = pending & ENABLE & {NUM_SRC{CTRL[0]}}; winner = lowest set index.
//  FSM:
//   IDLE:    eligible!=0 -> REQ, latch int_id_o=winner. Edge at T -> int_req_o at T+2.
//   REQ:     int_req_o=1, int_id_o stable (no preemption by higher source).
//            int_ack_i -> clear pending[id], SERVICE (req low next cycle).
//            else latched id no longer eligible (W1C, mask, CTRL[0]=0) -> IDLE, req 0.
//            ack wins over same-cycle withdrawal.
//   SERVICE: int_req_o=0, int_id_o holds. int_done_i or CLAIM write -> IDLE,
//            int_id_o kept until next latch. No nesting: new edges only pend.
//  int_ack_i outside REQ, int_done_i outside SERVICE: ignored.
//  Register write and FSM update same cycle: write applies, FSM sees old values.
//  Async reset mid-handshake: immediate return to reset state, pending lost.
// TESTING
//  1 Reset, ENABLE=0x1, CTRL=1, src0 rises at T -> PENDING=0x1 at T+1, req=1 id=0 at T+2.
//  2 src3 and src5 rise together, ENABLE=0xFF -> id=3, ack, done -> id=5 requested next.
//  3 In REQ id=2, write PENDING=0x4 (no ack) -> req=0, state IDLE next cycle.
//  4 src1 edge while SERVICE id=1 -> PENDING bit1 set, req stays 0 until done,
//    then req=1 id=1 two cycles after done.
//  5 ENABLE=0x0, src4 rises -> PENDING=0x10, no req; write ENABLE=0x10 -> req, id=4.
//  6 rst low during REQ -> req=0, id=0, PENDING=0 immediately; src held high
//    across release -> pending re-set one cycle after release.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: rising-edge capture into pending bits, per-source masking,
// fixed-priority arbitration (index 0 highest) and a req/ack/done handshake to the core.
module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] int_src_i,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    output logic [31:0]        data_o,
    output logic               int_req_o,
    output logic [4:0]         int_id_o,
    input  logic               int_ack_i,
    input  logic               int_done_i
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] A_CTRL    = 4'h0;
    localparam logic [3:0] A_ENABLE  = 4'h4;
    localparam logic [3:0] A_PENDING = 4'h8;
    localparam logic [3:0] A_CLAIM   = 4'hC;

    state_t             state_r;
    logic               ctrl_en_r;
    logic [NUM_SRC-1:0] enable_r;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] src_q_r;

    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] eligible_s;
    logic [NUM_SRC-1:0] id_hot_s;
    logic [NUM_SRC-1:0] w1c_s;
    logic [NUM_SRC-1:0] ack_clr_s;
    logic [4:0]         winner_s;
    logic               wr_ctrl_s;
    logic               wr_enable_s;
    logic               wr_pending_s;
    logic               wr_claim_s;
    logic               unused_s;

    // Only the low nibble of the address and the low data bits carry meaning.
    assign unused_s     = ^{addr_i[31:4], data_i};

    assign wr_ctrl_s    = we_i && (addr_i[3:0] == A_CTRL);
    assign wr_enable_s  = we_i && (addr_i[3:0] == A_ENABLE);
    assign wr_pending_s = we_i && (addr_i[3:0] == A_PENDING);
    assign wr_claim_s   = we_i && (addr_i[3:0] == A_CLAIM);

    assign rise_s       = int_src_i & ~src_q_r;
    assign eligible_s   = pending_r & enable_r & {NUM_SRC{ctrl_en_r}};
    assign w1c_s        = wr_pending_s ? data_i[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    assign ack_clr_s    = ((state_r == REQ) && int_ack_i) ? id_hot_s : {NUM_SRC{1'b0}};

    // Priority scan (downward so the lowest eligible index is the one left standing)
    // and a one-hot decode of the latched ID.
    always_comb begin
        winner_s = 5'd0;
        id_hot_s = {NUM_SRC{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            winner_s    = eligible_s[i] ? 5'(i) : winner_s;
            id_hot_s[i] = (int_id_o == 5'(i));
        end
    end

    // Register read mux, combinational from the address.
    always_comb begin
        case (addr_i[3:0])
            A_CTRL:    data_o = {28'd0, state_r, 1'b0, ctrl_en_r};
            A_ENABLE:  data_o = 32'(enable_r);
            A_PENDING: data_o = 32'(pending_r);
            A_CLAIM:   data_o = {24'd0, state_r, 1'b0, int_id_o};
            default:   data_o = 32'd0;
        endcase
    end

    // Edge capture, pending bookkeeping (a new edge beats a same-cycle clear) and config regs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q_r   <= {NUM_SRC{1'b0}};
            pending_r <= {NUM_SRC{1'b0}};
            enable_r  <= {NUM_SRC{1'b0}};
            ctrl_en_r <= 1'b0;
        end else begin
            src_q_r   <= int_src_i;
            pending_r <= (pending_r & ~(w1c_s | ack_clr_s)) | rise_s;
            if (wr_ctrl_s) begin
                ctrl_en_r <= data_i[0];
            end
            if (wr_enable_s) begin
                enable_r <= data_i[NUM_SRC-1:0];
            end
        end
    end

    // Handshake FSM; decisions use pre-write register values and outputs are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            int_req_o <= 1'b0;
            int_id_o  <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|eligible_s) begin
                        state_r   <= REQ;
                        int_req_o <= 1'b1;
                        int_id_o  <= winner_s;
                    end
                end
                REQ: begin
                    if (int_ack_i) begin
                        state_r   <= SERVICE;
                        int_req_o <= 1'b0;
                    end else if (!(|(eligible_s & id_hot_s))) begin
                        state_r   <= IDLE;
                        int_req_o <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (int_done_i || wr_claim_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    int_req_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
